// File: rtl/execute.sv
// execute: RV32 execute stage between decode and memory/writeback.
// Computes ADD sums, LW/SW effective addresses and the BEQ outcome, and
// registers them behind the valid/stall handshake. A taken BEQ pulses
// branch_redirect for one cycle and squashes the next FLUSH_DEPTH accepted
// slots.
// Optional feature: define EXEC_FORWARD_EN to forward a registered ADD
// result into rs1/rs2 of the instruction being captured.
module execute #(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_input,
    input  logic        stall_input,
    output logic        stall_output,
    output logic        valid_output,
    input  logic [31:0] pc,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rs2_idx,
    input  logic [4:0]  rd,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] immidiate_data,
    input  logic [3:0]  inst_type,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  rd_out,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal,
    output logic        branch_redirect,
    output logic [31:0] branch_target
);

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_DEPTH);

    localparam logic [3:0] T_NOP = 4'b0000;
    localparam logic [3:0] T_ADD = 4'b0001;
    localparam logic [3:0] T_BEQ = 4'b0010;
    localparam logic [3:0] T_LW  = 4'b0100;
    localparam logic [3:0] T_SW  = 4'b1000;

    // Output / state registers
    logic        valid_r;
    logic [31:0] alu_result_r;
    logic [31:0] store_data_r;
    logic [4:0]  rd_out_r;
    logic        reg_write_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        illegal_r;
    logic        redirect_r;
    logic [31:0] branch_target_r;
    logic [2:0]  squash_cnt_r;

    // Combinational next-state values
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [31:0] sum_rr_s;
    logic [31:0] sum_ri_s;
    logic        accept_s;
    logic        slot_s;
    logic        squashing_s;
    logic        take_s;
    logic        nxt_valid_s;
    logic [31:0] nxt_alu_s;
    logic [31:0] nxt_store_s;
    logic [4:0]  nxt_rd_s;
    logic        nxt_reg_write_s;
    logic        nxt_mem_read_s;
    logic        nxt_mem_write_s;
    logic        nxt_illegal_s;
    logic [2:0]  nxt_squash_s;

`ifdef EXEC_FORWARD_EN
    // Only a registered ADD may be forwarded: reg_write without mem_read.
    // rd_out is already 0 whenever reg_write is 0, so x0 never matches a
    // live producer, but the explicit check keeps the intent obvious.
    logic fwd_ok_s;
    assign fwd_ok_s = valid_r & reg_write_r & ~mem_read_r & (rd_out_r != 5'd0);
    assign op_a_s   = (fwd_ok_s && (rd_out_r == rs1_idx)) ? alu_result_r : rs1_data;
    assign op_b_s   = (fwd_ok_s && (rd_out_r == rs2_idx)) ? alu_result_r : rs2_data;
`else
    assign op_a_s = rs1_data;
    assign op_b_s = rs2_data;
    logic unused_idx_s;
    assign unused_idx_s = &{1'b0, rs1_idx, rs2_idx};
`endif

    assign sum_rr_s    = op_a_s + op_b_s;
    assign sum_ri_s    = op_a_s + immidiate_data;
    assign accept_s    = ~stall_input;
    assign slot_s      = valid_input & accept_s;
    assign squashing_s = (squash_cnt_r != 3'd0);
    assign take_s      = slot_s & ~squashing_s & (inst_type == T_BEQ) & (op_a_s == op_b_s);

    // Decode the incoming slot into the values the output register will load
    always_comb begin
        nxt_valid_s     = valid_input & ~squashing_s;
        nxt_alu_s       = 32'd0;
        nxt_store_s     = 32'd0;
        nxt_rd_s        = 5'd0;
        nxt_reg_write_s = 1'b0;
        nxt_mem_read_s  = 1'b0;
        nxt_mem_write_s = 1'b0;
        nxt_illegal_s   = 1'b0;
        if (nxt_valid_s) begin
            case (inst_type)
                T_ADD: begin
                    nxt_alu_s       = sum_rr_s;
                    nxt_reg_write_s = (rd != 5'd0);
                    nxt_rd_s        = (rd != 5'd0) ? rd : 5'd0;
                end
                T_LW: begin
                    nxt_alu_s       = sum_ri_s;
                    nxt_mem_read_s  = 1'b1;
                    nxt_reg_write_s = (rd != 5'd0);
                    nxt_rd_s        = (rd != 5'd0) ? rd : 5'd0;
                end
                T_SW: begin
                    nxt_alu_s       = sum_ri_s;
                    nxt_store_s     = op_b_s;
                    nxt_mem_write_s = 1'b1;
                end
                T_BEQ: begin
                    nxt_alu_s = 32'd0;
                end
                T_NOP: begin
                    nxt_alu_s = 32'd0;
                end
                default: begin
                    nxt_illegal_s = 1'b1;
                end
            endcase
        end else begin
            nxt_illegal_s = 1'b0;
        end
    end

    // Squash counter: decrement per accepted slot while squashing, reload on a taken BEQ
    always_comb begin
        nxt_squash_s = squash_cnt_r;
        if (slot_s && squashing_s) begin
            nxt_squash_s = squash_cnt_r - 3'd1;
        end else if (take_s) begin
            nxt_squash_s = FLUSH_CNT;
        end else begin
            nxt_squash_s = squash_cnt_r;
        end
    end

    // Pipeline output register; holds while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r         <= 1'b0;
            alu_result_r    <= 32'd0;
            store_data_r    <= 32'd0;
            rd_out_r        <= 5'd0;
            reg_write_r     <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            illegal_r       <= 1'b0;
            redirect_r      <= 1'b0;
            branch_target_r <= 32'd0;
            squash_cnt_r    <= 3'd0;
        end else begin
            // Redirect is a single-cycle pulse even if a stall follows
            redirect_r   <= take_s;
            squash_cnt_r <= nxt_squash_s;
            if (accept_s) begin
                valid_r      <= nxt_valid_s;
                alu_result_r <= nxt_alu_s;
                store_data_r <= nxt_store_s;
                rd_out_r     <= nxt_rd_s;
                reg_write_r  <= nxt_reg_write_s;
                mem_read_r   <= nxt_mem_read_s;
                mem_write_r  <= nxt_mem_write_s;
                illegal_r    <= nxt_illegal_s;
            end
            if (take_s) begin
                branch_target_r <= pc + immidiate_data;
            end
        end
    end

    assign valid_output    = valid_r;
    assign stall_output    = valid_r & stall_input;
    assign alu_result      = alu_result_r;
    assign store_data      = store_data_r;
    assign rd_out          = rd_out_r;
    assign reg_write       = reg_write_r;
    assign mem_read        = mem_read_r;
    assign mem_write       = mem_write_r;
    assign illegal         = illegal_r;
    assign branch_redirect = redirect_r;
    assign branch_target   = branch_target_r;

endmodule

// File: tb/tb_execute.sv
// tb_execute: directed-vector bench for the execute stage (FLUSH_DEPTH = 2).
module tb_execute;

    logic        clk;
    logic        rst;
    logic        valid_input;
    logic        stall_input;
    logic        stall_output;
    logic        valid_output;
    logic [31:0] pc;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] immidiate_data;
    logic [3:0]  inst_type;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_out;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic        branch_redirect;
    logic [31:0] branch_target;

    int err_cnt;
    int chk_cnt;

    execute #(.FLUSH_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_input     (valid_input),
        .stall_input     (stall_input),
        .stall_output    (stall_output),
        .valid_output    (valid_output),
        .pc              (pc),
        .rs1_idx         (rs1_idx),
        .rs2_idx         (rs2_idx),
        .rd              (rd),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .immidiate_data  (immidiate_data),
        .inst_type       (inst_type),
        .alu_result      (alu_result),
        .store_data      (store_data),
        .rd_out          (rd_out),
        .reg_write       (reg_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .illegal         (illegal),
        .branch_redirect (branch_redirect),
        .branch_target   (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] d, input logic [31:0] p);
        valid_input    = 1'b1;
        inst_type      = t;
        rs1_data       = a;
        rs2_data       = b;
        immidiate_data = imm;
        rd             = d;
        pc             = p;
        rs1_idx        = 5'd0;
        rs2_idx        = 5'd0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;

        // Reset held with random inputs
        rst            = 1'b0;
        valid_input    = 1'($urandom);
        stall_input    = 1'($urandom);
        pc             = $urandom;
        rs1_idx        = 5'($urandom);
        rs2_idx        = 5'($urandom);
        rd             = 5'($urandom);
        rs1_data       = $urandom;
        rs2_data       = $urandom;
        immidiate_data = $urandom;
        inst_type      = 4'($urandom);
        repeat (3) tick();
        check("rst_valid", 32'(valid_output), 32'd0);
        check("rst_stall", 32'(stall_output), 32'd0);
        check("rst_alu", alu_result, 32'd0);
        check("rst_store", store_data, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_ctl", {28'd0, reg_write, mem_read, mem_write, illegal}, 32'd0);
        check("rst_redirect", 32'(branch_redirect), 32'd0);
        check("rst_target", branch_target, 32'd0);

        // ADD 5+7 -> x3
        rst         = 1'b1;
        stall_input = 1'b0;
        drive(4'b0001, 32'd5, 32'd7, 32'd0, 5'd3, 32'h0);
        tick();
        check("add_valid", 32'(valid_output), 32'd1);
        check("add_alu", alu_result, 32'd12);
        check("add_rw", 32'(reg_write), 32'd1);
        check("add_rd", 32'(rd_out), 32'd3);

        // LW
        drive(4'b0100, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 5'd4, 32'h0);
        tick();
        check("lw_alu", alu_result, 32'h0FFC);
        check("lw_ctl", {28'd0, reg_write, mem_read, mem_write, illegal}, 32'b1100);
        check("lw_store", store_data, 32'd0);

        // SW
        drive(4'b1000, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 5'd4, 32'h0);
        tick();
        check("sw_alu", alu_result, 32'h0FFC);
        check("sw_store", store_data, 32'hAB);
        check("sw_ctl", {28'd0, reg_write, mem_read, mem_write, illegal}, 32'b0010);
        check("sw_rd", 32'(rd_out), 32'd0);

        // Taken BEQ then two squashed ADDs, third executes
        drive(4'b0010, 32'd9, 32'd9, 32'h10, 5'd0, 32'h40);
        tick();
        check("beq_redirect", 32'(branch_redirect), 32'd1);
        check("beq_target", branch_target, 32'h50);
        check("beq_valid", 32'(valid_output), 32'd1);
        check("beq_ctl", {28'd0, reg_write, mem_read, mem_write, illegal}, 32'd0);
        drive(4'b0001, 32'd1, 32'd1, 32'd0, 5'd2, 32'h44);
        tick();
        check("sq1_valid", 32'(valid_output), 32'd0);
        check("sq1_redirect", 32'(branch_redirect), 32'd0);
        check("sq1_target", branch_target, 32'h50);
        drive(4'b0001, 32'd1, 32'd1, 32'd0, 5'd2, 32'h48);
        tick();
        check("sq2_valid", 32'(valid_output), 32'd0);
        drive(4'b0001, 32'd2, 32'd3, 32'd0, 5'd2, 32'h50);
        tick();
        check("post_sq_valid", 32'(valid_output), 32'd1);
        check("post_sq_alu", alu_result, 32'd5);

        // Not-taken BEQ: no pulse, no squash
        drive(4'b0010, 32'd1, 32'd2, 32'h20, 5'd0, 32'h80);
        tick();
        check("nt_redirect", 32'(branch_redirect), 32'd0);
        check("nt_target", branch_target, 32'h50);
        drive(4'b0001, 32'd4, 32'd4, 32'd0, 5'd1, 32'h84);
        tick();
        check("nt_next_valid", 32'(valid_output), 32'd1);
        check("nt_next_alu", alu_result, 32'd8);

        // Stall with a valid ADD held
        drive(4'b0001, 32'd10, 32'd20, 32'd0, 5'd7, 32'h0);
        tick();
        stall_input = 1'b1;
        drive(4'b0001, 32'd99, 32'd1, 32'd0, 5'd8, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_alu", alu_result, 32'd30);
            check("stall_rd", 32'(rd_out), 32'd7);
            check("stall_out", 32'(stall_output), 32'd1);
        end
        stall_input = 1'b0;
        #1;
        check("unstall_out", 32'(stall_output), 32'd0);
        tick();
        check("unstall_alu", alu_result, 32'd100);

        // Redirect immediately followed by a stall pulses once
        drive(4'b0010, 32'd5, 32'd5, 32'h8, 5'd0, 32'h100);
        tick();
        check("rs_redirect", 32'(branch_redirect), 32'd1);
        check("rs_target", branch_target, 32'h108);
        stall_input = 1'b1;
        drive(4'b0001, 32'd1, 32'd1, 32'd0, 5'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_stall_redirect", 32'(branch_redirect), 32'd0);
            check("rs_stall_valid", 32'(valid_output), 32'd1);
        end
        // Bubble does not consume a squash slot
        stall_input = 1'b0;
        valid_input = 1'b0;
        tick();
        check("bubble_valid", 32'(valid_output), 32'd0);
        drive(4'b0001, 32'd1, 32'd1, 32'd0, 5'd1, 32'h0);
        tick();
        check("rs_sq1_valid", 32'(valid_output), 32'd0);
        tick();
        check("rs_sq2_valid", 32'(valid_output), 32'd0);
        drive(4'b0001, 32'd6, 32'd6, 32'd0, 5'd1, 32'h0);
        tick();
        check("rs_exec_valid", 32'(valid_output), 32'd1);
        check("rs_exec_alu", alu_result, 32'd12);

        // Taken BEQ inside the squash window does not reload the counter
        drive(4'b0010, 32'd3, 32'd3, 32'h40, 5'd0, 32'h200);
        tick();
        check("db_target", branch_target, 32'h240);
        drive(4'b0010, 32'd3, 32'd3, 32'h4, 5'd0, 32'h300);
        tick();
        check("db_sq_redirect", 32'(branch_redirect), 32'd0);
        check("db_sq_target", branch_target, 32'h240);
        drive(4'b0001, 32'd1, 32'd1, 32'd0, 5'd1, 32'h0);
        tick();
        check("db_sq2_valid", 32'(valid_output), 32'd0);
        drive(4'b0001, 32'd2, 32'd2, 32'd0, 5'd9, 32'h0);
        tick();
        check("db_exec_valid", 32'(valid_output), 32'd1);
        check("db_exec_alu", alu_result, 32'd4);

        // Edge cases
        drive(4'b0011, 32'd7, 32'd7, 32'd1, 5'd5, 32'h0);
        tick();
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_valid", 32'(valid_output), 32'd1);
        check("ill_ctl", {29'd0, reg_write, mem_read, mem_write}, 32'd0);
        check("ill_redirect", 32'(branch_redirect), 32'd0);
        drive(4'b0001, 32'd1, 32'd2, 32'd0, 5'd0, 32'h0);
        tick();
        check("rd0_rw", 32'(reg_write), 32'd0);
        check("rd0_rd", 32'(rd_out), 32'd0);
        check("rd0_ill", 32'(illegal), 32'd0);
        drive(4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2, 32'h0);
        tick();
        check("wrap_alu", alu_result, 32'd0);
        check("wrap_rw", 32'(reg_write), 32'd1);
        drive(4'b0000, 32'd8, 32'd9, 32'd4, 5'd3, 32'h0);
        tick();
        check("nop_valid", 32'(valid_output), 32'd1);
        check("nop_ctl", {28'd0, reg_write, mem_read, mem_write, illegal}, 32'd0);
        check("nop_alu", alu_result, 32'd0);

        // Forwarding: ADD x5 = 3+4, then ADD x6 = x5 + x5 with stale operands
        drive(4'b0001, 32'd3, 32'd4, 32'd0, 5'd5, 32'h0);
        tick();
        drive(4'b0001, 32'd0, 32'd0, 32'd0, 5'd6, 32'h0);
        rs1_idx = 5'd5;
        rs2_idx = 5'd5;
        tick();
`ifdef EXEC_FORWARD_EN
        check("fwd_alu", alu_result, 32'd14);
`else
        check("fwd_alu", alu_result, 32'd0);
`endif

        // Reset asserted mid-squash clears the counter
        drive(4'b0010, 32'd1, 32'd1, 32'h4, 5'd0, 32'h400);
        tick();
        check("mr_redirect", 32'(branch_redirect), 32'd1);
        rst = 1'b0;
        #2;
        check("mr_valid", 32'(valid_output), 32'd0);
        check("mr_redirect_clr", 32'(branch_redirect), 32'd0);
        check("mr_target", branch_target, 32'd0);
        drive(4'b0001, 32'd1, 32'd2, 32'd0, 5'd3, 32'h0);
        #2;
        rst = 1'b1;
        tick();
        check("mr_post_valid", 32'(valid_output), 32'd1);
        check("mr_post_alu", alu_result, 32'd3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
